// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential restoring divider (div_seq_ctrl).
//   - div_state_e   : controller states
//   - DIV_WIDTH     : default operand/quotient/remainder width
//   - DIV_CNT_W     : default iteration counter width (2**DIV_CNT_W > DIV_WIDTH)
//   - DIV_BY_ZERO_Q : quotient reported when the divisor is zero (all ones)
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  localparam logic [DIV_WIDTH-1:0] DIV_BY_ZERO_Q = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step.
//   a      in  WIDTH  partial remainder
//   q      in  WIDTH  dividend bits still to shift in / quotient bits so far
//   m      in  WIDTH  divisor magnitude
//   a_next out WIDTH  partial remainder after the step
//   q_next out WIDTH  q shifted left, new quotient bit in bit 0
// -----------------------------------------------------------------------------
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] a_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] a_sh;
  logic [WIDTH:0] trial;

  // a < m holds on entry, so 2a+1 fits in WIDTH+1 bits and the trial
  // subtraction's top bit is a reliable borrow/sign indicator.
  assign a_sh  = {a, q[WIDTH-1]};
  assign trial = a_sh - {1'b0, m};

  assign a_next = trial[WIDTH] ? a_sh[WIDTH-1:0] : trial[WIDTH-1:0];
  assign q_next = {q[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/div_seq_ctrl.sv
// -----------------------------------------------------------------------------
// div_seq_ctrl
// Multi-cycle restoring divider for DIV/DIVU, one quotient bit per clock.
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   start       in   divide request, sampled only when not busy
//   sign_en     in   1 = signed DIV, 0 = unsigned DIVU
//   dividend    in   WIDTH dividend, captured on accept
//   divisor     in   WIDTH divisor, captured on accept
//   busy        out  divide in flight (ITER/FIX); stall source
//   done        out  one-cycle pulse, results valid from this cycle
//   div_by_zero out  divisor was zero; held with the results
//   lo_out      out  WIDTH quotient
//   hi_out      out  WIDTH remainder
// Build option: define DIV_EARLY_OUT_EN to skip the iterations when
// |dividend| < |divisor| (quotient 0, remainder = dividend).
// -----------------------------------------------------------------------------
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign_en,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] lo_out,
  output logic [WIDTH-1:0] hi_out
);

  div_state_e       state, state_next;
  logic [WIDTH-1:0] a_r, q_r, m_r;
  logic [WIDTH-1:0] a_nx, q_nx;
  logic             q_neg, r_neg;
  logic [CNT_W-1:0] count;

  logic             accept;
  logic             dvs_zero;
  logic             early_out;
  logic             last_iter;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;

  // Magnitudes are only taken for signed divides; DIVU uses the raw bits.
  assign dvd_mag  = (sign_en && dividend[WIDTH-1]) ? -dividend : dividend;
  assign dvs_mag  = (sign_en && divisor[WIDTH-1])  ? -divisor  : divisor;
  assign dvs_zero = (divisor == '0);

  // DONE accepts too, so a new divide can follow back-to-back.
  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign last_iter = (count == CNT_W'(WIDTH - 1));

`ifdef DIV_EARLY_OUT_EN
  assign early_out = !dvs_zero && (dvd_mag < dvs_mag);
`else
  assign early_out = 1'b0;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .a      (a_r),
    .q      (q_r),
    .m      (m_r),
    .a_next (a_nx),
    .q_next (q_nx)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (accept) begin
          if (dvs_zero)       state_next = DONE;
          else if (early_out) state_next = FIX;
          else                state_next = ITER;
        end else begin
          state_next = IDLE;
        end
      end
      ITER: begin
        busy = 1'b1;
        if (last_iter) state_next = FIX;
      end
      FIX: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers and result holding.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r         <= '0;
      q_r         <= '0;
      m_r         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      count       <= '0;
      div_by_zero <= 1'b0;
      lo_out      <= '0;
      hi_out      <= '0;
    end else if (accept) begin
      m_r         <= dvs_mag;
      q_neg       <= sign_en && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      r_neg       <= sign_en && dividend[WIDTH-1];
      count       <= '0;
      div_by_zero <= dvs_zero;
      if (dvs_zero) begin
        // Results are final immediately: quotient all ones, raw dividend.
        a_r    <= '0;
        q_r    <= dvd_mag;
        lo_out <= WIDTH'(DIV_BY_ZERO_Q);
        hi_out <= dividend;
      end else begin
        a_r    <= early_out ? dvd_mag : '0;
        q_r    <= early_out ? '0 : dvd_mag;
        lo_out <= '0;
        hi_out <= '0;
      end
    end else begin
      case (state)
        ITER: begin
          a_r   <= a_nx;
          q_r   <= q_nx;
          count <= count + 1'b1;
        end
        FIX: begin
          // Remainder takes the dividend's sign, quotient the XOR of signs.
          lo_out <= q_neg ? -q_r : q_r;
          hi_out <= r_neg ? -a_r : a_r;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_seq_ctrl
// Directed self-checking bench for div_seq_ctrl (WIDTH = 32).
// -----------------------------------------------------------------------------
module tb_div_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sign_en = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] lo_out, hi_out;

  int n_checks = 0;
  int n_fail   = 0;

  int   lat;
  int   bcnt;
  logic bdone;
  int   extra;

  div_seq_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .sign_en     (sign_en),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .lo_out      (lo_out),
    .hi_out      (hi_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request now (caller is between negedge and posedge) and let the
  // next rising edge be the accept edge (cycle 0). Returns #1 into cycle 1.
  task automatic go(input logic s, input logic [31:0] dvd, input logic [31:0] dvs);
    start    = 1'b1;
    sign_en  = s;
    dividend = dvd;
    divisor  = dvs;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Sample at each negedge starting in cycle first_cyc until done; returns the
  // cycle number of done (-1 on timeout), busy cycles seen before it, and busy
  // during the done cycle. Returns positioned at the negedge of done.
  task automatic wait_done(input int first_cyc, output int l, output int bc, output logic bd);
    l  = -1;
    bc = 0;
    bd = 1'bx;
    for (int c = first_cyc; c < first_cyc + 100; c++) begin
      @(negedge clk);
      if (done) begin
        l  = c;
        bd = busy;
        break;
      end
      if (busy) bc++;
    end
  endtask

  // Count done pulses over n cycles.
  task automatic count_done(input int n, output int k);
    k = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (done) k++;
    end
  endtask

  initial begin
    // ---- reset -------------------------------------------------------------
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dbz",  32'(div_by_zero), 32'd0);
    check("rst_lo",   lo_out, 32'd0);
    check("rst_hi",   hi_out, 32'd0);

    // ---- unsigned 100 / 7 ----------------------------------------------------
    go(1'b0, 32'd100, 32'd7);
    wait_done(1, lat, bcnt, bdone);
    check("u_lat",       32'(lat), 32'd34);
    check("u_busy_cnt",  32'(bcnt), 32'd33);
    check("u_busy_done", 32'(bdone), 32'd0);
    check("u_lo",        lo_out, 32'd14);
    check("u_hi",        hi_out, 32'd2);
    check("u_dbz",       32'(div_by_zero), 32'd0);
    @(negedge clk);
    check("u_done_pulse", 32'(done), 32'd0);
    check("u_lo_hold",    lo_out, 32'd14);

    // ---- signed -100 / 7 -----------------------------------------------------
    go(1'b1, 32'hFFFF_FF9C, 32'd7);
    wait_done(1, lat, bcnt, bdone);
    check("s1_lat", 32'(lat), 32'd34);
    check("s1_lo",  lo_out, 32'hFFFF_FFF2);
    check("s1_hi",  hi_out, 32'hFFFF_FFFE);

    // ---- signed 100 / -7 -----------------------------------------------------
    @(negedge clk);
    go(1'b1, 32'd100, 32'hFFFF_FFF9);
    wait_done(1, lat, bcnt, bdone);
    check("s2_lo", lo_out, 32'hFFFF_FFF2);
    check("s2_hi", hi_out, 32'd2);

    // ---- divide by zero, then 9 / 3 clears the flag --------------------------
    @(negedge clk);
    go(1'b0, 32'h0000_1234, 32'd0);
    wait_done(1, lat, bcnt, bdone);
    check("z_lat",      32'(lat), 32'd1);
    check("z_busy_cnt", 32'(bcnt), 32'd0);
    check("z_busy",     32'(bdone), 32'd0);
    check("z_lo",       lo_out, 32'hFFFF_FFFF);
    check("z_hi",       hi_out, 32'h0000_1234);
    check("z_dbz",      32'(div_by_zero), 32'd1);
    @(negedge clk);
    check("z_dbz_hold", 32'(div_by_zero), 32'd1);
    go(1'b0, 32'd9, 32'd3);
    wait_done(1, lat, bcnt, bdone);
    check("z2_lat", 32'(lat), 32'd34);
    check("z2_dbz", 32'(div_by_zero), 32'd0);
    check("z2_lo",  lo_out, 32'd3);
    check("z2_hi",  hi_out, 32'd0);

    // ---- signed overflow, then back-to-back 15 / 4 in the DONE cycle ---------
    @(negedge clk);
    go(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1, lat, bcnt, bdone);
    check("ov_lat", 32'(lat), 32'd34);
    check("ov_lo",  lo_out, 32'h8000_0000);
    check("ov_hi",  hi_out, 32'd0);
    check("ov_dbz", 32'(div_by_zero), 32'd0);
    go(1'b0, 32'd15, 32'd4);
    wait_done(1, lat, bcnt, bdone);
    check("b2b_lat", 32'(lat), 32'd34);
    check("b2b_lo",  lo_out, 32'd3);
    check("b2b_hi",  hi_out, 32'd3);

    // ---- start pulses at cycles 5 and 20 are ignored -------------------------
    @(negedge clk);
    go(1'b0, 32'd200, 32'd9);                 // now in cycle 1
    repeat (4) @(posedge clk);
    #1;                                       // cycle 5
    go(1'b0, 32'd1, 32'd1);                   // now in cycle 6
    repeat (14) @(posedge clk);
    #1;                                       // cycle 20
    go(1'b1, 32'd5, 32'd5);                   // now in cycle 21
    wait_done(21, lat, bcnt, bdone);
    check("ign_lat", 32'(lat), 32'd34);
    check("ign_lo",  lo_out, 32'd22);
    check("ign_hi",  hi_out, 32'd2);
    count_done(40, extra);
    check("ign_one_done", 32'(extra), 32'd0);

    // ---- reset at cycle 10 aborts without done -------------------------------
    @(negedge clk);
    go(1'b0, 32'd1000, 32'd3);                // now in cycle 1
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;                            // cycle 10
    @(posedge clk);
    #1 rst = 1'b0;                            // cycle 11
    @(negedge clk);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_done", 32'(done), 32'd0);
    check("mr_lo",   lo_out, 32'd0);
    check("mr_hi",   hi_out, 32'd0);
    check("mr_dbz",  32'(div_by_zero), 32'd0);
    count_done(40, extra);
    check("mr_no_done", 32'(extra), 32'd0);

    // ---- 3 / 10: early-out build finishes in cycle 2 -------------------------
    @(negedge clk);
    go(1'b0, 32'd3, 32'd10);
    wait_done(1, lat, bcnt, bdone);
`ifdef DIV_EARLY_OUT_EN
    check("eo_lat", 32'(lat), 32'd2);
`else
    check("eo_lat", 32'(lat), 32'd34);
`endif
    check("eo_lo", lo_out, 32'd0);
    check("eo_hi", hi_out, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
Multi-cycle sequencer for restoring division, one quotient bit per clock, used for the CPU's DIV/DIVU instructions.
- Accepts operands on a start pulse, converts signed operands to magnitudes, and iterates WIDTH restoring steps.
- Applies sign correction and presents quotient on LO and remainder on HI with busy/done handshake.
- busy is the stall source for the control unit while a divide is in flight.

Parameters:
- WIDTH, 32, operand/quotient/remainder width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  request; sampled only when not busy.
- sign_en  in  1  1 = signed DIV, 0 = unsigned DIVU; captured with start.
- dividend  in  WIDTH  captured on accept.
- divisor  in  WIDTH  captured on accept.
- busy  out  1  high from the cycle after accept until the cycle before done.
- done  out  1  one-cycle pulse; results valid from this cycle.
- div_by_zero  out  1  set with done when divisor==0; held with results.
- lo_out  out  WIDTH  quotient.
- hi_out  out  WIDTH  remainder.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, div_by_zero=0, lo_out=0, hi_out=0; counter=0.
- States: IDLE, ITER, FIX, DONE.
- Accept: start=1 in IDLE or DONE. Registers magnitudes (abs only if sign_en), q_neg=sign_en&(dvd[MSB]^dvs[MSB]), r_neg=sign_en&dvd[MSB]; A=0, Q=|dividend|, count=0, next=ITER.
- start in ITER/FIX is ignored; no queuing.
- ITER: each cycle computes {A,Q}<<=1; trial=A-|divisor| in WIDTH+1 bits. If trial is non-negative: A=trial, Q[0]=1; otherwise A is unchanged and Q[0]=0. count++; at count==WIDTH-1, next=FIX.
- FIX: lo=q_neg ? -Q : Q; hi=r_neg ? -A : A (two's complement, WIDTH bits). Next=DONE.
- DONE: done=1 for exactly this cycle. lo_out/hi_out/div_by_zero hold until the next accept. Next=IDLE, or ITER if start is accepted here (back-to-back).
- Latency: accept on cycle 0; ITER cycles 1..WIDTH; FIX cycle WIDTH+1; done in cycle WIDTH+2 (34 for WIDTH=32). busy=1 in cycles 1..WIDTH+1.
- Divide-by-zero (divisor==0 at accept): skip ITER and FIX; go straight to DONE with done in cycle 1. lo_out=all ones, hi_out=dividend unmodified, div_by_zero=1. busy stays 0.
- Signed overflow (-2^(W-1) / -1): magnitude 2^(W-1) fits unsigned; result lo=0x80000000, hi=0. No flag.
- Reset mid-operation: abort immediately to reset values; the partial result is discarded and done is not pulsed.
- Accept clears div_by_zero and the previous results; lo_out and hi_out update only at FIX/DONE.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined: at accept, if |dividend| < |divisor| and divisor != 0, skip ITER and go to FIX with Q=0, A=|dividend|. done in cycle 2; the sign fix still applies, so hi=dividend and lo=0.
- Undefined: every nonzero-divisor divide takes the full WIDTH+2 cycles.

Decomposition:
- Package div_pkg holds:
  - the state enum (IDLE, ITER, FIX, DONE);
  - DIV_WIDTH=32 and DIV_CNT_W=6;
  - the divide-by-zero quotient constant (all ones).
- Sub-module div_step: purely combinational single restoring step. Inputs are A, Q, M; outputs are next A and next Q. The controller instantiates it once and feeds it from registers.

Test Plan:
- Unsigned: sign_en=0, 100/7 → done at cycle 34, lo=14, hi=2, div_by_zero=0; busy high cycles 1..33.
- Signed: sign_en=1, -100/7 → lo=0xFFFFFFF2 (-14), hi=0xFFFFFFFE (-2). Also 100/-7 → lo=-14, hi=2.
- Divide by zero: 0x1234/0 → done at cycle 1, lo=0xFFFFFFFF, hi=0x1234, div_by_zero=1. A following 9/3 clears the flag, lo=3, hi=0.
- Overflow and back-to-back: sign_en=1, 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0. Assert start during the DONE cycle with 15/4 → accepted, second done 34 cycles later, lo=3, hi=3.
- Start while busy and reset mid-op:
  - start pulses at cycles 5 and 20 of a divide are ignored; exactly one done results.
  - rst at cycle 10 → all outputs 0 next cycle, no done pulse.
- With DIV_EARLY_OUT_EN defined: 3/10 → done at cycle 2, lo=0, hi=3. Undefined, the same divide → done at cycle 34.
